// File: rtl/des_round_engine.sv
// Iterative DES/Feistel engine: one round per clock, ROUNDS rounds per block,
// ready/valid handshake on both sides, optional IP/FP wrapping.
module des_round_engine #(
    parameter int unsigned ROUNDS = 16,
    parameter int unsigned USE_IP = 1
) (
    input  logic        Clk,
    input  logic        ResetN,
    input  logic        InValid,
    output logic        InReady,
    input  logic [63:0] DataIn,
    input  logic [63:0] KeyIn,
    input  logic        Decrypt,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [63:0] DataOut,
    output logic        Busy
);

    localparam int unsigned HALF_W = 32;
    localparam int unsigned CD_W   = 28;
    localparam int unsigned CNT_W  = 5;

    // Permutation tables: entry k names the 1-based source bit (bit 1 = MSB)
    // that lands in output position k+1; unused tail entries are zero.
    typedef int unsigned tab_t [64];

    localparam tab_t IP_T = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam tab_t FP_T = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
    localparam tab_t PC1_T = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4,
        0, 0, 0, 0, 0, 0, 0, 0};
    localparam tab_t PC2_T = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32,
        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    localparam tab_t E_T = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9,
        8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1,
        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    localparam tab_t P_T = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25,
        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    // S-boxes, 64 nibbles each, indexed row*16+col, first entry in the top nibble.
    localparam logic [255:0] SBOX [8] = '{
        {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}};

    localparam logic [1:0] SHIFTS [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    // Total key rotation over the configured rounds, reduced mod 28.
    function automatic int unsigned shift_sum(input int unsigned n);
        int unsigned sum;
        sum = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i < n) sum += 32'(SHIFTS[4'(i)]);
        end
        return sum % CD_W;
    endfunction

    localparam int unsigned PRE_ROT = shift_sum(ROUNDS);

    // Generic bit permutation; src and result are right-aligned in 64 bits.
    function automatic logic [63:0] perm(input logic [63:0] src, input int unsigned src_w,
                                         input tab_t tab, input int unsigned dst_w);
        logic [63:0] res;
        res = '0;
        for (int unsigned k = 0; k < 64; k++) begin
            if (k < dst_w) res[6'(dst_w - 1 - k)] = src[6'(src_w - tab[6'(k)])];
        end
        return res;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int unsigned n);
        logic [55:0] xx;
        xx = {x, x};
        return xx[6'(55 - n) -: 28];
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input int unsigned n);
        logic [55:0] xx;
        xx = {x, x};
        return xx[6'(27 + n) -: 28];
    endfunction

    // Eight S-boxes, 6-bit slices MSB-first; row = outer bits, column = inner four.
    function automatic logic [31:0] sbox_layer(input logic [47:0] x);
        logic [31:0]  res;
        logic [255:0] box;
        logic [5:0]   six;
        logic [7:0]   idx;
        res = '0;
        for (int unsigned s = 0; s < 8; s++) begin
            six = x[6'(47 - 6 * s) -: 6];
            idx = {2'b00, six[5], six[0], six[4:1]};
            box = SBOX[3'(s)];
            res[5'(31 - 4 * s) -: 4] = box[8'(8'd255 - {idx[5:0], 2'b00}) -: 4];
        end
        return res;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] rr, input logic [47:0] kk);
        logic [47:0] e;
        e = 48'(perm(64'(rr), 32, E_T, 48));
        return 32'(perm(64'(sbox_layer(e ^ kk)), 32, P_T, 32));
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [HALF_W-1:0]   l, r, r_nxt;
    logic [CD_W-1:0]     c, d, c_load, d_load, c_rot, d_rot, c_nxt, d_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                mode;
    logic [63:0]         ip_blk, preout, fin_blk;
    logic [55:0]         pc1_key;
    logic [47:0]         sub_key;
    logic [1:0]          shift_enc, shift_dec;

    // Block/key loading and the single Feistel round for the current count.
    always_comb begin
        ip_blk = DataIn;
        if (USE_IP != 0) ip_blk = perm(DataIn, 64, IP_T, 64);
        pc1_key = 56'(perm(KeyIn, 64, PC1_T, 56));
        c_load  = pc1_key[55:28];
        d_load  = pc1_key[27:0];
        if (Decrypt) begin
            c_load = rotl28(pc1_key[55:28], PRE_ROT);
            d_load = rotl28(pc1_key[27:0], PRE_ROT);
        end
        shift_enc = SHIFTS[cnt[3:0]];
        shift_dec = SHIFTS[4'(ROUNDS - 1) - cnt[3:0]];
        c_rot   = rotl28(c, 32'(shift_enc));
        d_rot   = rotl28(d, 32'(shift_enc));
        c_nxt   = c_rot;
        d_nxt   = d_rot;
        sub_key = 48'(perm(64'({c_rot, d_rot}), 56, PC2_T, 48));
        if (mode) begin
            sub_key = 48'(perm(64'({c, d}), 56, PC2_T, 48));
            c_nxt   = rotr28(c, 32'(shift_dec));
            d_nxt   = rotr28(d, 32'(shift_dec));
        end
        r_nxt   = l ^ feistel(r, sub_key);
        preout  = {r_nxt, r};
        fin_blk = preout;
        if (USE_IP != 0) fin_blk = perm(preout, 64, FP_T, 64);
    end

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state    <= IDLE;
            l        <= '0;
            r        <= '0;
            c        <= '0;
            d        <= '0;
            cnt      <= '0;
            mode     <= 1'b0;
            DataOut  <= '0;
            OutValid <= 1'b0;
            Busy     <= 1'b0;
            InReady  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (InValid && InReady) begin
                        l       <= ip_blk[63:32];
                        r       <= ip_blk[31:0];
                        c       <= c_load;
                        d       <= d_load;
                        mode    <= Decrypt;
                        cnt     <= '0;
                        Busy    <= 1'b1;
                        InReady <= 1'b0;
                        state   <= RUN;
                    end else begin
                        InReady <= 1'b1;
                    end
                end
                RUN: begin
                    l   <= r;
                    r   <= r_nxt;
                    c   <= c_nxt;
                    d   <= d_nxt;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(ROUNDS - 1)) begin
                        DataOut  <= fin_blk;
                        OutValid <= 1'b1;
                        Busy     <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (OutReady) begin
                        OutValid <= 1'b0;
                        InReady  <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_round_engine.sv
// Bench for des_round_engine: FIPS vectors, backpressure, mid-run reset,
// continuous-issue throughput and random round trips at ROUNDS=1 and 5.
module tb_des_round_engine;

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] PT1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT1 = 64'h85E813540F0AB405;
    localparam logic [63:0] PT2 = 64'h8787878787878787;
    localparam logic [63:0] CT2 = 64'h0000000000000000;

    logic        clk = 1'b0;
    logic        reset_n, in_valid, decrypt, out_ready;
    logic [63:0] data_in, key_in;
    int          sel;

    logic        d16_valid, d1_valid, d5_valid;
    logic        d16_ready, d1_ready, d5_ready;
    logic        d16_ovalid, d1_ovalid, d5_ovalid;
    logic        d16_busy, d1_busy, d5_busy;
    logic [63:0] d16_dout, d1_dout, d5_dout;

    logic        s_ready, s_valid, s_busy;
    logic [63:0] s_dout;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    des_round_engine #(.ROUNDS(16), .USE_IP(1)) dut16 (
        .Clk(clk), .ResetN(reset_n), .InValid(d16_valid), .InReady(d16_ready),
        .DataIn(data_in), .KeyIn(key_in), .Decrypt(decrypt), .OutValid(d16_ovalid),
        .OutReady(out_ready), .DataOut(d16_dout), .Busy(d16_busy));

    des_round_engine #(.ROUNDS(1), .USE_IP(0)) dut1 (
        .Clk(clk), .ResetN(reset_n), .InValid(d1_valid), .InReady(d1_ready),
        .DataIn(data_in), .KeyIn(key_in), .Decrypt(decrypt), .OutValid(d1_ovalid),
        .OutReady(out_ready), .DataOut(d1_dout), .Busy(d1_busy));

    des_round_engine #(.ROUNDS(5), .USE_IP(0)) dut5 (
        .Clk(clk), .ResetN(reset_n), .InValid(d5_valid), .InReady(d5_ready),
        .DataIn(data_in), .KeyIn(key_in), .Decrypt(decrypt), .OutValid(d5_ovalid),
        .OutReady(out_ready), .DataOut(d5_dout), .Busy(d5_busy));

    // Route the shared stimulus to one engine and view that engine's outputs.
    always_comb begin
        d16_valid = in_valid && (sel == 0);
        d1_valid  = in_valid && (sel == 1);
        d5_valid  = in_valid && (sel == 2);
        case (sel)
            1: begin s_ready = d1_ready; s_valid = d1_ovalid; s_busy = d1_busy; s_dout = d1_dout; end
            2: begin s_ready = d5_ready; s_valid = d5_ovalid; s_busy = d5_busy; s_dout = d5_dout; end
            default: begin s_ready = d16_ready; s_valid = d16_ovalid; s_busy = d16_busy; s_dout = d16_dout; end
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Issue one block on engine s, wait for its result and consume it.
    task automatic run_block(input int s, input logic [63:0] din, input logic [63:0] key,
                             input logic dec, input logic has_exp, input logic [63:0] expv,
                             input int lat_exp, output logic [63:0] res);
        int   waitc;
        int   lat;
        logic got;
        sel = s; data_in = din; key_in = key; decrypt = dec; out_ready = 1'b1; in_valid = 1'b1;
        if (has_exp) exp_q.push_back(expv);
        got = 1'b0;
        waitc = 0;
        while (!got && waitc < 50) begin
            got = s_ready;
            tick();
            waitc++;
        end
        in_valid = 1'b0;
        data_in = ~din; key_in = ~key; decrypt = ~dec;
        res = '0;
        if (!got) begin
            check("accept_timeout", 64'(got), 64'd1);
            if (has_exp) void'(exp_q.pop_back());
            return;
        end
        check("busy_in_run", 64'(s_busy), 64'd1);
        lat = 0;
        while (!s_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("latency", 64'(lat), 64'(lat_exp));
        if (s_valid) begin
            res = s_dout;
            if (exp_q.size() > 0) check("data_out", s_dout, exp_q.pop_front());
            tick();
            check("ready_after_handshake", 64'(s_ready), 64'd1);
        end else if (has_exp) begin
            void'(exp_q.pop_front());
        end
    endtask

    logic [63:0] tv_key [4] = '{K1, K1, K2, K2};
    logic [63:0] tv_din [4] = '{PT1, CT1, PT2, CT2};
    logic        tv_dec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [63:0] tv_exp [4] = '{CT1, PT1, CT2, PT2};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] res, ct, x, k, bp_exp;
        logic        got, seen;
        int          waitc, issued, outs, cyc, last_acc;
        logic        acc;

        sel = 0; reset_n = 1'b0; in_valid = 1'b0; decrypt = 1'b0; out_ready = 1'b0;
        data_in = '0; key_in = '0;

        // Reset state
        tick(); tick();
        check("rst_in_ready", 64'(d16_ready), 64'd0);
        check("rst_out_valid", 64'(d16_ovalid), 64'd0);
        check("rst_busy", 64'(d16_busy), 64'd0);
        check("rst_data_out", d16_dout, 64'd0);
        check("rst_in_ready_r1", 64'(d1_ready), 64'd0);
        reset_n = 1'b1;
        tick();
        check("in_ready_after_release", 64'(d16_ready), 64'd1);

        // FIPS known-answer vectors
        run_block(0, PT1, K1, 1'b0, 1'b1, CT1, 16, res);
        run_block(0, CT1, K1, 1'b1, 1'b1, PT1, 16, res);
        run_block(0, PT2, K2, 1'b0, 1'b1, CT2, 16, res);

        // Backpressure: result held while OutReady is low, new block refused
        sel = 0; data_in = PT1; key_in = K1; decrypt = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        exp_q.push_back(CT1);
        got = 1'b0; waitc = 0;
        while (!got && waitc < 50) begin got = s_ready; tick(); waitc++; end
        in_valid = 1'b0;
        check("bp_accept", 64'(got), 64'd1);
        waitc = 0;
        while (!s_valid && waitc < 100) begin tick(); waitc++; end
        check("bp_latency", 64'(waitc), 64'd16);
        bp_exp = exp_q.pop_front();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin in_valid = 1'b1; data_in = PT2; key_in = K2; end
            if (i == 5) in_valid = 1'b0;
            check("bp_data_stable", s_dout, bp_exp);
            check("bp_in_ready_low", 64'(s_ready), 64'd0);
            check("bp_out_valid_held", 64'(s_valid), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 64'(s_valid), 64'd0);
        check("bp_release_idle", 64'(s_ready), 64'd1);
        tick();
        check("bp_no_new_block", 64'(s_busy), 64'd0);

        // Reset during round 7 aborts the block
        data_in = PT1; key_in = K1; decrypt = 1'b0; in_valid = 1'b1;
        got = 1'b0; waitc = 0;
        while (!got && waitc < 50) begin got = s_ready; tick(); waitc++; end
        in_valid = 1'b0;
        check("abort_accept", 64'(got), 64'd1);
        repeat (7) tick();
        check("abort_busy_before", 64'(s_busy), 64'd1);
        reset_n = 1'b0;
        tick();
        check("abort_rst_busy", 64'(s_busy), 64'd0);
        check("abort_rst_ready", 64'(s_ready), 64'd0);
        check("abort_rst_dout", s_dout, 64'd0);
        reset_n = 1'b1;
        tick();
        check("abort_idle_after", 64'(s_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin seen |= s_valid; tick(); end
        check("abort_no_output", 64'(seen), 64'd0);
        run_block(0, PT1, K1, 1'b0, 1'b1, CT1, 16, res);

        // Continuous InValid: every acceptance produces exactly one correct result
        sel = 0; out_ready = 1'b1; issued = 0; outs = 0; cyc = 0; last_acc = -100;
        data_in = tv_din[0]; key_in = tv_key[0]; decrypt = tv_dec[0]; in_valid = 1'b1;
        while ((issued < 8 || outs < 8) && cyc < 400) begin
            acc = in_valid && s_ready;
            if (s_valid) begin
                outs++;
                if (exp_q.size() > 0) check("tp_data", s_dout, exp_q.pop_front());
                else check("tp_unexpected_output", 64'(exp_q.size()), 64'd1);
            end
            if (acc) begin
                exp_q.push_back(tv_exp[issued % 4]);
                if (issued > 0) check("tp_spacing", 64'((cyc - last_acc) >= 17), 64'd1);
                last_acc = cyc;
                issued++;
            end
            tick();
            cyc++;
            if (acc) begin
                if (issued < 8) begin
                    data_in = tv_din[issued % 4]; key_in = tv_key[issued % 4]; decrypt = tv_dec[issued % 4];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        check("tp_accepts", 64'(issued), 64'd8);
        check("tp_outputs", 64'(outs), 64'd8);
        check("tp_queue_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        // Random encrypt/decrypt round trips at ROUNDS=1 and ROUNDS=5
        for (int i = 0; i < 1000; i++) begin
            k = {$urandom, $urandom};
            x = {$urandom, $urandom};
            run_block(1, x, k, 1'b0, 1'b0, '0, 1, ct);
            run_block(1, ct, k, 1'b1, 1'b1, x, 1, res);
            k = {$urandom, $urandom};
            x = {$urandom, $urandom};
            run_block(2, x, k, 1'b0, 1'b0, '0, 5, ct);
            run_block(2, ct, k, 1'b1, 1'b1, x, 5, res);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
